// File: rtl/shift_sched.sv
// Scheduler that shares one 8-bit shifter between two requesters.
// Define SHIFT_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has priority.
module shift_sched (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [0:7] req0_data,
   input  logic [3:0] req0_cnt,
   input  logic       req0_dir,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [0:7] req1_data,
   input  logic [3:0] req1_cnt,
   input  logic       req1_dir,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [0:7] rsp_data,
   output logic       rsp_id,
   output logic [0:7] sh_din,
   output logic       sh_load,
   output logic       sh_lr,
   input  logic [0:7] sh_dout
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] CAPT  = 3'd3;
   localparam logic [2:0] RESP  = 3'd4;

   logic [2:0] state;
   logic [0:7] cmd_data;
   logic       cmd_dir;
   logic [3:0] cnt;

   logic       grant0;
   logic       grant1;
   logic       idle;
   logic       take;
   logic [0:7] sel_data;
   logic [3:0] sel_cnt;
   logic [3:0] sel_eff;
   logic       sel_dir;

`ifdef SHIFT_SCHED_RR_EN
   // last = ID served most recently; the other side wins a tie
   logic last;

   assign grant0 = req0_valid & (~req1_valid | last);
   assign grant1 = req1_valid & ~grant0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (take) begin
         last <= grant1;
      end
   end
`else
   assign grant0 = req0_valid;
   assign grant1 = req1_valid & ~req0_valid;
`endif

   assign idle       = (state == IDLE);
   assign req0_ready = idle & grant0;
   assign req1_ready = idle & grant1;
   assign take       = req0_ready | req1_ready;

   assign sel_data = grant1 ? req1_data : req0_data;
   assign sel_cnt  = grant1 ? req1_cnt  : req0_cnt;
   assign sel_dir  = grant1 ? req1_dir  : req0_dir;
   assign sel_eff  = (sel_cnt > 4'd8) ? 4'd8 : sel_cnt;

   assign rsp_valid = (state == RESP);
   assign sh_load   = (state == LOAD);
   assign sh_din    = sh_load ? cmd_data : 8'h00;
   assign sh_lr     = cmd_dir;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cmd_data <= 8'h00;
         cmd_dir  <= 1'b0;
         cnt      <= 4'd0;
         rsp_data <= 8'h00;
         rsp_id   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  cmd_data <= sel_data;
                  cmd_dir  <= sel_dir;
                  cnt      <= sel_eff;
                  rsp_id   <= grant1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               state <= (cnt == 4'd0) ? CAPT : SHIFT;
            end
            SHIFT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= CAPT;
               end
            end
            // shifter advances once more at this edge; that value is unused
            CAPT: begin
               rsp_data <= sh_dout;
               state    <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sched.sv
// Randomized scoreboard bench for shift_sched with a behavioural shifter.
// Honours SHIFT_SCHED_RR_EN to pick the expected arbitration rule.
module tb_shift_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid, req0_ready, req0_dir;
   logic [0:7] req0_data;
   logic [3:0] req0_cnt;
   logic       req1_valid, req1_ready, req1_dir;
   logic [0:7] req1_data;
   logic [3:0] req1_cnt;
   logic       rsp_valid, rsp_ready, rsp_id;
   logic [0:7] rsp_data;
   logic [0:7] sh_din, sh_dout;
   logic       sh_load, sh_lr;
   logic [0:7] sh_q;

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp;
      bit         id;
      bit         dir;
      int         n;
      int         acc;
   } item_t;

   item_t sb[$];
   bit    glog[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    acc_cnt = 0;
   int    done_cnt = 0;
   int    done_cyc = -10;
   bit    last = 1'b1;
   bit    in_rsp = 1'b0;
   logic [7:0] hold_d;
   bit    hold_id;

   shift_sched dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_data(req0_data), .req0_cnt(req0_cnt), .req0_dir(req0_dir),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_data(req1_data), .req1_cnt(req1_cnt), .req1_dir(req1_dir),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id),
      .sh_din(sh_din), .sh_load(sh_load), .sh_lr(sh_lr),
      .sh_dout(sh_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Shifter: load, else shift one place with zero fill (LR=1 toward bit 0)
   always @(posedge clk) begin
      if (sh_load) sh_q <= sh_din;
      else if (sh_lr) sh_q <= sh_q << 1;
      else sh_q <= sh_q >> 1;
   end
   assign sh_dout = sh_q;

   function automatic int eff(input logic [3:0] c);
      return (c > 4'd8) ? 8 : int'(c);
   endfunction

   function automatic logic [7:0] model(input logic [7:0] d,
                                        input logic [3:0] c,
                                        input bit dir);
      int n;
      n = eff(c);
      return dir ? 8'(d << n) : 8'(d >> n);
   endfunction

   // Issue side: expected grant, then push on every request handshake
   always @(negedge clk) begin
      bit idle_exp, g0, g1;
      item_t it;
      if (!rst_n) begin
         acc_cnt = 0;
         last = 1'b1;
      end else begin
         idle_exp = (acc_cnt == done_cnt) && (done_cyc != cyc);
`ifdef SHIFT_SCHED_RR_EN
         g0 = req0_valid && (!req1_valid || last);
`else
         g0 = req0_valid;
`endif
         g1 = req1_valid && !g0;
         checks++;
         if ({req0_ready, req1_ready} !== {idle_exp && g0, idle_exp && g1}) begin
            errors++;
            $display("FAIL ready cyc=%0d got r0=%b r1=%b want r0=%b r1=%b",
                     cyc, req0_ready, req1_ready, idle_exp && g0, idle_exp && g1);
         end
         if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            it.id   = req1_ready;
            it.data = it.id ? req1_data : req0_data;
            it.dir  = it.id ? req1_dir : req0_dir;
            it.n    = eff(it.id ? req1_cnt : req0_cnt);
            it.exp  = model(it.data, it.id ? req1_cnt : req0_cnt, it.dir);
            it.acc  = cyc;
            sb.push_back(it);
            glog.push_back(it.id);
            acc_cnt++;
            last = it.id;
         end
      end
   end

   // Monitor: shifter drive and response channel against the scoreboard
   always @(negedge clk) begin
      int lat;
      if (!rst_n) begin
         sb.delete();
         in_rsp = 1'b0;
         done_cnt = 0;
         done_cyc = -10;
      end else begin
         checks++;
         if (sh_load) begin
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL load_spurious cyc=%0d", cyc);
            end else if (cyc != sb[0].acc + 1 || sh_din !== sb[0].data) begin
               errors++;
               $display("FAIL load cyc=%0d got din=%h want din=%h at cyc %0d",
                        cyc, sh_din, sb[0].data, sb[0].acc + 1);
            end
         end else if (sh_din !== 8'h00) begin
            errors++;
            $display("FAIL din_idle cyc=%0d got %h want 00", cyc, sh_din);
         end
         if (sb.size() > 0 && cyc > sb[0].acc) begin
            checks++;
            if (sh_lr !== sb[0].dir) begin
               errors++;
               $display("FAIL lr cyc=%0d got %b want %b", cyc, sh_lr, sb[0].dir);
            end
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_spurious cyc=%0d data=%h", cyc, rsp_data);
            end else begin
               if (!in_rsp) begin
                  lat = cyc - sb[0].acc;
                  checks += 3;
                  if (lat != sb[0].n + 3) begin
                     errors++;
                     $display("FAIL latency got %0d want %0d", lat, sb[0].n + 3);
                  end
                  if (rsp_data !== sb[0].exp) begin
                     errors++;
                     $display("FAIL rsp_data got %h want %h (in %h n=%0d dir=%b)",
                              rsp_data, sb[0].exp, sb[0].data, sb[0].n, sb[0].dir);
                  end
                  if (rsp_id !== sb[0].id) begin
                     errors++;
                     $display("FAIL rsp_id got %b want %b", rsp_id, sb[0].id);
                  end
                  in_rsp = 1'b1;
                  hold_d = rsp_data;
                  hold_id = rsp_id;
               end else begin
                  checks++;
                  if (rsp_data !== hold_d || rsp_id !== hold_id) begin
                     errors++;
                     $display("FAIL rsp_hold got %h/%b want %h/%b",
                              rsp_data, rsp_id, hold_d, hold_id);
                  end
               end
               if (rsp_ready) begin
                  void'(sb.pop_front());
                  in_rsp = 1'b0;
                  done_cnt++;
                  done_cyc = cyc;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   task automatic check_reset();
      chk("rst_rsp_valid", 8'(rsp_valid), 8'h00);
      chk("rst_rsp_data", rsp_data, 8'h00);
      chk("rst_rsp_id", 8'(rsp_id), 8'h00);
      chk("rst_sh_load", 8'(sh_load), 8'h00);
      chk("rst_sh_din", sh_din, 8'h00);
      chk("rst_sh_lr", 8'(sh_lr), 8'h00);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_reset();
   endtask

   task automatic send(input bit id, input logic [7:0] d,
                       input logic [3:0] c, input bit dir);
      bit got;
      got = 1'b0;
      @(posedge clk);
      #1;
      if (id) begin
         req1_data = d; req1_cnt = c; req1_dir = dir; req1_valid = 1'b1;
      end else begin
         req0_data = d; req0_cnt = c; req0_dir = dir; req0_valid = 1'b1;
      end
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = id ? req1_ready : req0_ready;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL send_timeout id=%0d", id);
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = (acc_cnt == done_cnt) && (done_cyc != cyc) && !rsp_valid;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL idle_timeout acc=%0d done=%0d", acc_cnt, done_cnt);
      end
   endtask

   task automatic wait_rsp();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = rsp_valid;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rsp_timeout");
      end
   endtask

   initial begin
      req0_valid = 0; req0_data = 0; req0_cnt = 0; req0_dir = 0;
      req1_valid = 0; req1_data = 0; req1_cnt = 0; req1_dir = 0;
      rsp_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_reset();

      rsp_ready = 1'b1;
      send(1'b0, 8'hF0, 4'd2, 1'b1);
      wait_idle();
      send(1'b1, 8'h81, 4'd0, 1'b0);
      wait_idle();
      send(1'b0, 8'hFF, 4'd12, 1'b0);
      wait_idle();

      // response held off while both requesters wait
      rsp_ready = 1'b0;
      send(1'b0, 8'h5A, 4'd3, 1'b1);
      wait_rsp();
      @(posedge clk);
      #1;
      req0_data = 8'h33; req0_cnt = 4'd1; req0_dir = 1'b0; req0_valid = 1'b1;
      req1_data = 8'hC4; req1_cnt = 4'd2; req1_dir = 1'b1; req1_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();

      // continuous contention from a fresh pointer
      pulse_reset();
      glog.delete();
      @(posedge clk);
      #1;
      req0_data = 8'h96; req0_cnt = 4'd1; req0_dir = 1'b1; req0_valid = 1'b1;
      req1_data = 8'h69; req1_cnt = 4'd2; req1_dir = 1'b0; req1_valid = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();
      checks++;
      if (glog.size() < 4) begin
         errors++;
         $display("FAIL grant_count got %0d want >=4", glog.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_SCHED_RR_EN
            chk("grant_seq", 8'(glog[i]), 8'(i % 2));
`else
            chk("grant_seq", 8'(glog[i]), 8'h00);
`endif
         end
      end

      // reset during SHIFT abandons the command
      send(1'b0, 8'hC3, 4'd7, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_reset();
      repeat (15) @(posedge clk);
      send(1'b1, 8'h3C, 4'd5, 1'b0);
      wait_idle();

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         req0_valid = ($urandom_range(0, 2) == 0);
         req1_valid = ($urandom_range(0, 2) == 0);
         req0_data = 8'($urandom);
         req1_data = 8'($urandom);
         req0_cnt = 4'($urandom);
         req1_cnt = 4'($urandom);
         req0_dir = 1'($urandom);
         req1_dir = 1'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
